ext_sram_ws_ctrl: RTL and testbench
===================================

# ext_sram_ws_ctrl

Parametrised async-SRAM controller between the openMSP430 memory bus and an off-chip asynchronous SRAM. Generalises the single-cycle DE-board SRAM bridge with configurable data/address width, byte lanes, per-direction wait states, read-to-write bus turnaround and a `ram_wait` stall handshake. It sits in the board top level between the core memory port (or a wait-capable bus fabric) and the SRAM pins.

## Interface
- `ADDR_WIDTH`, 9: host word-address width; must satisfy `ADDR_WIDTH <= SRAM_AW`.
- `SRAM_AW`, 18: SRAM pin address width; the host address is zero-extended to this width.
- `DATA_WIDTH`, 16: word width; a multiple of 8. `NB = DATA_WIDTH/8` byte lanes.
- `RD_WS`, 1: extra read wait cycles, range 0..15.
- `WR_WS`, 1: write-strobe length in cycles, range 1..15.
- `TURN_CYC`, 1: idle cycles inserted between a read and a following write, range 0..3.

Ports:
- `clk` in 1: single clock; all logic on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `ram_addr` in ADDR_WIDTH: word address.
- `ram_cen` in 1: request, active low.
- `ram_wen` in NB: per-lane write enable, active low; all ones means read.
- `ram_din` in DATA_WIDTH: write data.
- `ram_dout` out DATA_WIDTH: last read data, held until the next read completes.
- `ram_wait` out 1: busy. Combinational, high whenever the state is not IDLE.
- `SRAM_DQ` inout DATA_WIDTH: data bus.
- `SRAM_ADDR` out SRAM_AW: registered address.
- `SRAM_BE_N` out NB: byte enables, active low.
- `SRAM_CE_N`, `SRAM_OE_N`, `SRAM_WE_N` out 1 each: registered strobes, active low.

## Operation
- **States:** IDLE, TURN, RD, WR_SU, WR_STB, WR_HLD.
- **Acceptance:** a request is accepted only on a rising edge where the state is IDLE and `ram_cen=0`.
  - Address, data and `ram_wen` are latched at that edge.
  - Inputs are ignored in every other state. The host keeps its request asserted until it sees `ram_wait` low.
- **Read** (`&ram_wen`): IDLE→RD.
  - RD lasts RD_WS+1 cycles with CE_N=0, OE_N=0, WE_N=1, BE_N=0, and DQ tri-stated.
  - On the final RD edge, SRAM_DQ is captured into `ram_dout`, `last_rd` is set, and the state goes to IDLE.
- **Write** (any `ram_wen` bit 0): IDLE→TURN if `last_rd=1` and TURN_CYC>0, otherwise IDLE→WR_SU.
  - TURN: lasts TURN_CYC cycles, all strobes high, DQ tri-stated.
  - WR_SU: 1 cycle. CE_N=0, WE_N=1, OE_N=1, BE_N=ram_wen, DQ driven.
  - WR_STB: WR_WS cycles with WE_N=0.
  - WR_HLD: 1 cycle with WE_N=1 and DQ still driven. Then IDLE, with `last_rd` cleared.
- **DQ driver:** enabled only in WR_SU, WR_STB and WR_HLD. A read following a write therefore needs no turnaround.
- **Idle strobes:** in IDLE and TURN, CE_N, OE_N, WE_N and all BE_N are 1. SRAM_ADDR holds its last value.
- **Wait counter:** one down-counter, 4 bits, loaded on entry to RD, WR_STB or TURN. The state advances when the counter is 0.

## Timing
- **Edge labels:** E0 is the accepting edge. Strobes and address are valid from E0 and registered, so the SRAM sees them glitch-free.
- **Read:**
  - Data is captured at edge E(RD_WS+1), and `ram_dout` is valid after that edge.
  - The earliest next acceptance is E(RD_WS+2). Read throughput is RD_WS+2 cycles per access.
- **Write:**
  - WE_N falls at E1 and rises at E(WR_WS+1). IDLE is reached at E(WR_WS+2), and the next acceptance is E(WR_WS+3).
  - Add TURN_CYC cycles when the write follows a read.
- **`ram_wait`:** high from just after E0 until the edge that returns to IDLE. It is low in IDLE even while `ram_cen=0`.
- **Reset values:** state IDLE; CE_N/OE_N/WE_N/BE_N all 1; DQ Z; SRAM_ADDR 0; `ram_dout` 0; `last_rd` 0; counter 0; `ram_wait` 0.
- **Reset mid-operation:** strobes deassert and DQ releases asynchronously. An in-flight write is abandoned and an in-flight read does not update `ram_dout`.

## Structure
- **Shared package `ext_sram_pkg`:**
  - state enum (IDLE=0, TURN, RD, WR_SU, WR_STB, WR_HLD);
  - counter width constant (4);
  - function `nb_lanes(DATA_WIDTH)`.
- **Sub-module `ext_sram_wscnt`:** a loadable 4-bit down-counter with a `zero` flag, instantiated once.
- **Elaboration checks:** illegal parameter values (DATA_WIDTH not a multiple of 8, `ADDR_WIDTH>SRAM_AW`, WR_WS=0) cause an elaboration error.

## Test plan
- **Read, RD_WS=2, preset 16'hA5C3:** addr 9'h012, ram_cen=0, ram_wen=2'b11 → SRAM_ADDR=18'h00012, OE_N low for 3 cycles, `ram_dout`=16'hA5C3 after E3, `ram_wait` high over E0–E3.
- **Byte write, WR_WS=1:** ram_wen=2'b10, din=16'h1234 → BE_N=2'b10, WE_N low exactly 1 cycle (E1–E2), DQ driven E0–E3; readback gives the low byte 8'h34 with the upper byte unchanged.
- **Read then write, TURN_CYC=2:** → 2 cycles with all strobes high and DQ=Z before WR_SU; write then read → no gap and no DQ overlap.
- **Back-to-back reads with ram_cen held low:** → accepts every RD_WS+2 cycles; ram_cen=1 between reads → `ram_dout` holds its value.
- **Reset mid-write:** assert rst during WR_STB → WE_N=1 and DQ=Z immediately; after release, state IDLE and `ram_wait`=0.
- **DATA_WIDTH=32:** NB=4, ram_wen=4'b0110 → BE_N=4'b0110; RD_WS=0 read completes in 1 cycle.

Source files
------------

// File: rtl/ext_sram_ws_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// ext_sram_pkg
// Shared definitions for the asynchronous SRAM controller:
//   - state_t  : controller state encoding (IDLE=0, TURN, RD, WR_SU, WR_STB, WR_HLD)
//   - CNT_W    : width of the wait-state down-counter
//   - nb_lanes : number of byte lanes for a given data width
// ---------------------------------------------------------------------------
package ext_sram_pkg;

    localparam int CNT_W = 4;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        TURN   = 3'd1,
        RD     = 3'd2,
        WR_SU  = 3'd3,
        WR_STB = 3'd4,
        WR_HLD = 3'd5
    } state_t;

    function automatic int nb_lanes(input int data_width);
        return data_width / 8;
    endfunction

endpackage

// File: rtl/ext_sram_ws_ctrl_if.sv
// ---------------------------------------------------------------------------
// ext_sram_ws_ctrl_if
// Host-side memory bus (openMSP430 style) with a wait handshake.
//   ram_addr  : word address            (master -> slave)
//   ram_cen   : request, active low     (master -> slave)
//   ram_wen   : per-lane write enable, active low, all ones = read
//   ram_din   : write data              (master -> slave)
//   ram_dout  : last read data          (slave -> master)
//   ram_wait  : busy, request not taken (slave -> master)
// ---------------------------------------------------------------------------
interface ext_sram_ws_ctrl_if
    import ext_sram_pkg::*;
#(
    parameter int ADDR_WIDTH = 9,
    parameter int DATA_WIDTH = 16
);
    localparam int NB = nb_lanes(DATA_WIDTH);

    logic [ADDR_WIDTH-1:0] ram_addr;
    logic                  ram_cen;
    logic [NB-1:0]         ram_wen;
    logic [DATA_WIDTH-1:0] ram_din;
    logic [DATA_WIDTH-1:0] ram_dout;
    logic                  ram_wait;

    modport master (
        output ram_addr, ram_cen, ram_wen, ram_din,
        input  ram_dout, ram_wait
    );

    modport slave (
        input  ram_addr, ram_cen, ram_wen, ram_din,
        output ram_dout, ram_wait
    );

endinterface

// File: rtl/ext_sram_ws_ctrl_wscnt.sv
// ---------------------------------------------------------------------------
// ext_sram_wscnt
// Loadable down-counter used to time wait states.
//   clk, rst    : clock, asynchronous active-high reset
//   load_i      : load load_val_i (has priority over dec_i)
//   load_val_i  : value to load
//   dec_i       : decrement by one, saturating at zero
//   zero_o      : counter currently equals zero
// ---------------------------------------------------------------------------
module ext_sram_wscnt
    import ext_sram_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    input  logic             dec_i,
    output logic             zero_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/ext_sram_ws_ctrl.sv
// ---------------------------------------------------------------------------
// ext_sram_ws_ctrl
// Async-SRAM controller between the openMSP430 memory bus and off-chip SRAM,
// with per-direction wait states, read->write turnaround and a busy handshake.
//   clk, rst   : clock, asynchronous active-high reset
//   bus        : host bus (slave side), see ext_sram_ws_ctrl_if
//   SRAM_DQ    : bidirectional data bus, driven only during write phases
//   SRAM_ADDR  : registered address (host address zero-extended)
//   SRAM_BE_N  : registered byte enables, active low
//   SRAM_CE_N, SRAM_OE_N, SRAM_WE_N : registered strobes, active low
// ---------------------------------------------------------------------------
module ext_sram_ws_ctrl
    import ext_sram_pkg::*;
#(
    parameter int ADDR_WIDTH = 9,
    parameter int SRAM_AW    = 18,
    parameter int DATA_WIDTH = 16,
    parameter int RD_WS      = 1,
    parameter int WR_WS      = 1,
    parameter int TURN_CYC   = 1
)(
    input  logic                              clk,
    input  logic                              rst,
    ext_sram_ws_ctrl_if.slave                 bus,
    inout  wire  [DATA_WIDTH-1:0]             SRAM_DQ,
    output logic [SRAM_AW-1:0]                SRAM_ADDR,
    output logic [nb_lanes(DATA_WIDTH)-1:0]   SRAM_BE_N,
    output logic                              SRAM_CE_N,
    output logic                              SRAM_OE_N,
    output logic                              SRAM_WE_N
);

    localparam int NB = nb_lanes(DATA_WIDTH);

    // Counter preloads: a phase of N cycles loads N-1 on entry and leaves
    // on the edge where the counter reads zero.
    localparam logic [CNT_W-1:0] RD_LD   = CNT_W'(RD_WS);
    localparam logic [CNT_W-1:0] WR_LD   = (WR_WS > 0) ? CNT_W'(WR_WS - 1) : '0;
    localparam logic [CNT_W-1:0] TURN_LD = (TURN_CYC > 0) ? CNT_W'(TURN_CYC - 1) : '0;
    localparam bit               HAS_TURN = (TURN_CYC > 0);

    // Elaboration-time parameter checks
    generate
        if ((DATA_WIDTH % 8) != 0 || DATA_WIDTH < 8) begin : g_bad_dw
            $error("ext_sram_ws_ctrl: DATA_WIDTH must be a non-zero multiple of 8");
        end
        if (ADDR_WIDTH > SRAM_AW) begin : g_bad_aw
            $error("ext_sram_ws_ctrl: ADDR_WIDTH must not exceed SRAM_AW");
        end
        if (WR_WS < 1 || WR_WS > 15) begin : g_bad_wr
            $error("ext_sram_ws_ctrl: WR_WS must be in 1..15");
        end
        if (RD_WS < 0 || RD_WS > 15) begin : g_bad_rd
            $error("ext_sram_ws_ctrl: RD_WS must be in 0..15");
        end
        if (TURN_CYC < 0 || TURN_CYC > 3) begin : g_bad_turn
            $error("ext_sram_ws_ctrl: TURN_CYC must be in 0..3");
        end
    endgenerate

    state_t                state_q,   state_d;
    logic                  last_rd_q, last_rd_d;
    logic [NB-1:0]         wen_q,     wen_d;
    logic [DATA_WIDTH-1:0] wdata_q,   wdata_d;
    logic [DATA_WIDTH-1:0] dout_q,    dout_d;
    logic [SRAM_AW-1:0]    addr_q,    addr_d;
    logic                  ce_n_q,    ce_n_d;
    logic                  oe_n_q,    oe_n_d;
    logic                  we_n_q,    we_n_d;
    logic [NB-1:0]         be_n_q,    be_n_d;
    logic                  dq_oe_q,   dq_oe_d;

    logic                  cnt_load;
    logic [CNT_W-1:0]      cnt_load_val;
    logic                  cnt_dec;
    logic                  cnt_zero;

    ext_sram_wscnt u_wscnt (
        .clk        (clk),
        .rst        (rst),
        .load_i     (cnt_load),
        .load_val_i (cnt_load_val),
        .dec_i      (cnt_dec),
        .zero_o     (cnt_zero)
    );

    // Next-state and datapath
    always_comb begin
        state_d      = state_q;
        last_rd_d    = last_rd_q;
        wen_d        = wen_q;
        wdata_d      = wdata_q;
        dout_d       = dout_q;
        addr_d       = addr_q;
        cnt_load     = 1'b0;
        cnt_load_val = '0;
        cnt_dec      = 1'b0;

        case (state_q)
            IDLE: begin
                if (!bus.ram_cen) begin
                    addr_d  = SRAM_AW'(bus.ram_addr);
                    wen_d   = bus.ram_wen;
                    wdata_d = bus.ram_din;
                    if (&bus.ram_wen) begin
                        state_d      = RD;
                        cnt_load     = 1'b1;
                        cnt_load_val = RD_LD;
                    end else if (last_rd_q && HAS_TURN) begin
                        state_d      = TURN;
                        cnt_load     = 1'b1;
                        cnt_load_val = TURN_LD;
                    end else begin
                        state_d = WR_SU;
                    end
                end
            end
            TURN: begin
                if (cnt_zero) state_d = WR_SU;
                else          cnt_dec = 1'b1;
            end
            RD: begin
                if (cnt_zero) begin
                    dout_d    = SRAM_DQ;
                    last_rd_d = 1'b1;
                    state_d   = IDLE;
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            WR_SU: begin
                state_d      = WR_STB;
                cnt_load     = 1'b1;
                cnt_load_val = WR_LD;
            end
            WR_STB: begin
                if (cnt_zero) state_d = WR_HLD;
                else          cnt_dec = 1'b1;
            end
            WR_HLD: begin
                last_rd_d = 1'b0;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Pin strobes are decoded from the next state and registered, so the
    // SRAM sees them change cleanly on the same edge the state changes.
    always_comb begin
        ce_n_d  = 1'b1;
        oe_n_d  = 1'b1;
        we_n_d  = 1'b1;
        be_n_d  = '1;
        dq_oe_d = 1'b0;
        case (state_d)
            RD: begin
                ce_n_d = 1'b0;
                oe_n_d = 1'b0;
                be_n_d = '0;
            end
            WR_SU, WR_HLD: begin
                ce_n_d  = 1'b0;
                be_n_d  = wen_d;
                dq_oe_d = 1'b1;
            end
            WR_STB: begin
                ce_n_d  = 1'b0;
                we_n_d  = 1'b0;
                be_n_d  = wen_d;
                dq_oe_d = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            last_rd_q <= 1'b0;
            wen_q     <= '1;
            wdata_q   <= '0;
            dout_q    <= '0;
            addr_q    <= '0;
            ce_n_q    <= 1'b1;
            oe_n_q    <= 1'b1;
            we_n_q    <= 1'b1;
            be_n_q    <= '1;
            dq_oe_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            last_rd_q <= last_rd_d;
            wen_q     <= wen_d;
            wdata_q   <= wdata_d;
            dout_q    <= dout_d;
            addr_q    <= addr_d;
            ce_n_q    <= ce_n_d;
            oe_n_q    <= oe_n_d;
            we_n_q    <= we_n_d;
            be_n_q    <= be_n_d;
            dq_oe_q   <= dq_oe_d;
        end
    end

    assign SRAM_DQ   = dq_oe_q ? wdata_q : {DATA_WIDTH{1'bz}};
    assign SRAM_ADDR = addr_q;
    assign SRAM_BE_N = be_n_q;
    assign SRAM_CE_N = ce_n_q;
    assign SRAM_OE_N = oe_n_q;
    assign SRAM_WE_N = we_n_q;

    assign bus.ram_dout = dout_q;
    assign bus.ram_wait = (state_q != IDLE);

endmodule

// File: tb/tb_ext_sram_ws_ctrl.sv
module tb_ext_sram_ws_ctrl;

    localparam int RD_WS_A = 2;
    localparam int WR_WS_A = 1;
    localparam int TURN_A  = 2;
    localparam int WR_WS_B = 2;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Instance A: 16-bit, RD_WS=2, WR_WS=1, TURN_CYC=2
    // ------------------------------------------------------------------
    ext_sram_ws_ctrl_if #(.ADDR_WIDTH(9), .DATA_WIDTH(16)) bus_a ();
    wire  [15:0] dq_a;
    logic [17:0] sa_addr;
    logic [1:0]  sa_be;
    logic        sa_ce, sa_oe, sa_we;

    ext_sram_ws_ctrl #(
        .ADDR_WIDTH(9), .SRAM_AW(18), .DATA_WIDTH(16),
        .RD_WS(RD_WS_A), .WR_WS(WR_WS_A), .TURN_CYC(TURN_A)
    ) dut_a (
        .clk(clk), .rst(rst), .bus(bus_a.slave),
        .SRAM_DQ(dq_a), .SRAM_ADDR(sa_addr), .SRAM_BE_N(sa_be),
        .SRAM_CE_N(sa_ce), .SRAM_OE_N(sa_oe), .SRAM_WE_N(sa_we)
    );

    function automatic logic [15:0] pat_a(input int i);
        if (i == 18) return 16'hA5C3;
        return 16'(i * 40503 + 4660);
    endfunction

    logic [15:0] sram_a [0:511];
    bit          init_a = 1'b0;
    assign dq_a = (!sa_ce && !sa_oe && sa_we) ? sram_a[sa_addr[8:0]] : 16'bz;
    always @(negedge clk) begin
        if (!init_a) begin
            for (int i = 0; i < 512; i++) sram_a[i] <= pat_a(i);
            init_a <= 1'b1;
        end else if (!sa_ce && !sa_we) begin
            for (int l = 0; l < 2; l++)
                if (!sa_be[l]) sram_a[sa_addr[8:0]][l*8 +: 8] <= dq_a[l*8 +: 8];
        end
    end

    // ------------------------------------------------------------------
    // Instance B: 32-bit, RD_WS=0, WR_WS=2, TURN_CYC=0
    // ------------------------------------------------------------------
    ext_sram_ws_ctrl_if #(.ADDR_WIDTH(9), .DATA_WIDTH(32)) bus_b ();
    wire  [31:0] dq_b;
    logic [17:0] sb_addr;
    logic [3:0]  sb_be;
    logic        sb_ce, sb_oe, sb_we;

    ext_sram_ws_ctrl #(
        .ADDR_WIDTH(9), .SRAM_AW(18), .DATA_WIDTH(32),
        .RD_WS(0), .WR_WS(WR_WS_B), .TURN_CYC(0)
    ) dut_b (
        .clk(clk), .rst(rst), .bus(bus_b.slave),
        .SRAM_DQ(dq_b), .SRAM_ADDR(sb_addr), .SRAM_BE_N(sb_be),
        .SRAM_CE_N(sb_ce), .SRAM_OE_N(sb_oe), .SRAM_WE_N(sb_we)
    );

    logic [31:0] sram_b [0:15];
    bit          init_b = 1'b0;
    assign dq_b = (!sb_ce && !sb_oe && sb_we) ? sram_b[sb_addr[3:0]] : 32'bz;
    always @(negedge clk) begin
        if (!init_b) begin
            for (int i = 0; i < 16; i++) sram_b[i] <= 32'h11223344 + 32'(i);
            init_b <= 1'b1;
        end else if (!sb_ce && !sb_we) begin
            for (int l = 0; l < 4; l++)
                if (!sb_be[l]) sram_b[sb_addr[3:0]][l*8 +: 8] <= dq_b[l*8 +: 8];
        end
    end

    // ------------------------------------------------------------------
    // Reference model for instance A (plain memory + last-op flag)
    // ------------------------------------------------------------------
    typedef struct {
        bit          is_rd;
        logic [15:0] dout;
        logic [17:0] addr;
        logic [1:0]  be_n;
        int          busy;
        int          turn;
    } exp_t;

    exp_t        sbq[$];
    logic [15:0] ref_mem [0:511];
    bit          ref_last_rd = 1'b0;
    logic [15:0] ref_dout = 16'h0;
    int          acc_cyc = 0;

    task automatic op_a(input logic [8:0] a, input logic [1:0] wen, input logic [15:0] din,
                        input bit hold, input bit push);
        int   guard;
        exp_t e;
        guard = 0;
        @(negedge clk);
        bus_a.ram_addr = a;
        bus_a.ram_wen  = wen;
        bus_a.ram_din  = din;
        bus_a.ram_cen  = 1'b0;
        while (bus_a.ram_wait && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (bus_a.ram_wait) begin
            chk("accept_timeout", 64'(bus_a.ram_wait), 64'd0);
            bus_a.ram_cen = 1'b1;
            return;
        end
        @(posedge clk);
        acc_cyc = cyc;
        if (push) begin
            e.addr = 18'(a);
            if (&wen) begin
                e.is_rd = 1'b1;
                e.dout  = ref_mem[a];
                e.be_n  = 2'b00;
                e.busy  = RD_WS_A + 1;
                e.turn  = 0;
                ref_dout    = ref_mem[a];
                ref_last_rd = 1'b1;
            end else begin
                e.is_rd = 1'b0;
                e.dout  = 16'h0;
                e.be_n  = wen;
                e.turn  = ref_last_rd ? TURN_A : 0;
                e.busy  = e.turn + WR_WS_A + 2;
                for (int l = 0; l < 2; l++)
                    if (!wen[l]) ref_mem[a][l*8 +: 8] = din[l*8 +: 8];
                ref_last_rd = 1'b0;
            end
            sbq.push_back(e);
        end
        #1;
        if (!hold) bus_a.ram_cen = 1'b1;
    endtask

    // ------------------------------------------------------------------
    // Monitor: profiles each busy period of instance A and checks it
    // against the next scoreboard entry when ram_wait drops.
    // ------------------------------------------------------------------
    bit          m_active = 1'b0;
    bit          m_seen_ce;
    int          m_busy, m_we_lo, m_oe_lo, m_dq_on, m_turn, m_bad_turn;
    logic [17:0] m_addr;
    logic [1:0]  m_be;

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (rst) begin
                m_active = 1'b0;
            end else if (bus_a.ram_wait) begin
                if (!m_active) begin
                    m_active = 1'b1; m_seen_ce = 1'b0;
                    m_busy = 0; m_we_lo = 0; m_oe_lo = 0; m_dq_on = 0;
                    m_turn = 0; m_bad_turn = 0;
                    m_addr = '0; m_be = '1;
                end
                m_busy++;
                if (!sa_we) m_we_lo++;
                if (!sa_oe) m_oe_lo++;
                if (dut_a.dq_oe_q) m_dq_on++;
                if (sa_ce) begin
                    m_turn++;
                    if (dut_a.dq_oe_q || !sa_oe || !sa_we || sa_be != 2'b11) m_bad_turn++;
                end else if (!m_seen_ce) begin
                    m_seen_ce = 1'b1;
                    m_addr = sa_addr;
                    m_be   = sa_be;
                end
            end else if (m_active) begin
                m_active = 1'b0;
                if (sbq.size() == 0) begin
                    chk("unexpected_completion", 64'd1, 64'd0);
                end else begin
                    e = sbq.pop_front();
                    $display("txn %s addr=%0h be_n=%b busy=%0d turn=%0d dout=%0h",
                             e.is_rd ? "RD" : "WR", m_addr, m_be, m_busy, m_turn, bus_a.ram_dout);
                    chk("addr",       64'(m_addr),     64'(e.addr));
                    chk("be_n",       64'(m_be),       64'(e.be_n));
                    chk("busy_cyc",   64'(m_busy),     64'(e.busy));
                    chk("turn_cyc",   64'(m_turn),     64'(e.turn));
                    chk("turn_clean", 64'(m_bad_turn), 64'd0);
                    chk("we_low_cyc", 64'(m_we_lo),    e.is_rd ? 64'd0 : 64'(WR_WS_A));
                    chk("oe_low_cyc", 64'(m_oe_lo),    e.is_rd ? 64'(RD_WS_A + 1) : 64'd0);
                    chk("dq_drv_cyc", 64'(m_dq_on),    e.is_rd ? 64'd0 : 64'(WR_WS_A + 2));
                    if (e.is_rd) chk("rd_data", 64'(bus_a.ram_dout), 64'(e.dout));
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    initial begin : stim
        int n;
        int prev;
        bit hold;
        logic [1:0] w;

        for (int i = 0; i < 512; i++) ref_mem[i] = pat_a(i);
        bus_a.ram_cen = 1'b1; bus_a.ram_wen = 2'b11; bus_a.ram_addr = '0; bus_a.ram_din = '0;
        bus_b.ram_cen = 1'b1; bus_b.ram_wen = 4'hF;  bus_b.ram_addr = '0; bus_b.ram_din = '0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_wait",  64'(bus_a.ram_wait), 64'd0);
        chk("rst_dout",  64'(bus_a.ram_dout), 64'd0);
        chk("rst_addr",  64'(sa_addr),        64'd0);
        chk("rst_strb",  64'({sa_ce, sa_oe, sa_we, sa_be}), 64'h1F);
        chk("rst_dq_oe", 64'(dut_a.dq_oe_q),  64'd0);
        chk("rst_b_be",  64'(sb_be),          64'hF);
        @(negedge clk);
        rst = 1'b0;

        // Directed: byte write, readback, preset read, read->write turnaround,
        // write->read with no gap.
        op_a(9'h020, 2'b10, 16'h1234, 1'b0, 1'b1);
        op_a(9'h020, 2'b11, 16'h0000, 1'b0, 1'b1);
        op_a(9'h012, 2'b11, 16'h0000, 1'b0, 1'b1);
        op_a(9'h012, 2'b00, 16'hBEEF, 1'b0, 1'b1);
        op_a(9'h012, 2'b11, 16'h0000, 1'b0, 1'b1);

        // Back-to-back reads with ram_cen held low
        prev = -1;
        for (int i = 0; i < 4; i++) begin
            op_a(9'(9'h030 + i), 2'b11, 16'h0, 1'b1, 1'b1);
            if (prev >= 0) chk("b2b_interval", 64'(acc_cyc - prev), 64'(RD_WS_A + 2));
            prev = acc_cyc;
        end
        bus_a.ram_cen = 1'b1;

        // ram_dout holds while the bus is idle
        repeat (8) @(posedge clk);
        #1;
        chk("dout_hold", 64'(bus_a.ram_dout), 64'(ref_dout));

        // Randomised traffic
        for (int i = 0; i < 40; i++) begin
            w    = ($urandom_range(0, 1) == 1) ? 2'b11 : 2'($urandom_range(0, 3));
            hold = ($urandom_range(0, 2) == 0);
            op_a(9'($urandom_range(0, 31)), w, 16'($urandom), hold, 1'b1);
            if (!hold) repeat ($urandom_range(0, 3)) @(posedge clk);
        end
        bus_a.ram_cen = 1'b1;

        // Reset in the middle of a write strobe
        op_a(9'h040, 2'b00, 16'hCAFE, 1'b0, 1'b0);
        n = 0;
        while (sa_we && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("we_fell", 64'(sa_we), 64'd0);
        #1;
        rst = 1'b1;
        #1;
        chk("rst_mid_we",   64'(sa_we),          64'd1);
        chk("rst_mid_ce",   64'(sa_ce),          64'd1);
        chk("rst_mid_dq",   64'(dut_a.dq_oe_q),  64'd0);
        chk("rst_mid_wait", 64'(bus_a.ram_wait), 64'd0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        ref_last_rd = 1'b0;
        ref_dout    = 16'h0;
        @(posedge clk);
        #1;
        chk("post_rst_wait", 64'(bus_a.ram_wait), 64'd0);
        chk("post_rst_dout", 64'(bus_a.ram_dout), 64'd0);
        op_a(9'h040, 2'b11, 16'h0, 1'b0, 1'b1);
        op_a(9'h041, 2'b01, 16'h77AA, 1'b0, 1'b1);
        op_a(9'h041, 2'b11, 16'h0, 1'b0, 1'b1);

        // Instance B: 32-bit lanes, RD_WS=0
        @(negedge clk);
        bus_b.ram_addr = 9'h003; bus_b.ram_wen = 4'b0110; bus_b.ram_din = 32'hDEADBEEF;
        bus_b.ram_cen  = 1'b0;
        @(posedge clk);
        #1;
        bus_b.ram_cen = 1'b1;
        chk("b_be_n", 64'(sb_be),   64'h6);
        chk("b_addr", 64'(sb_addr), 64'h3);
        n = 0;
        while (bus_b.ram_wait && n < 50) begin
            n++;
            @(posedge clk);
            #1;
        end
        chk("b_wr_busy", 64'(n), 64'(WR_WS_B + 2));
        $display("txn B WR addr=3 be_n=0110 busy=%0d", n);
        @(negedge clk);
        bus_b.ram_wen = 4'hF;
        bus_b.ram_cen = 1'b0;
        @(posedge clk);
        #1;
        bus_b.ram_cen = 1'b1;
        chk("b_rd_oe",   64'(sb_oe),          64'd0);
        chk("b_rd_wait", 64'(bus_b.ram_wait), 64'd1);
        @(posedge clk);
        #1;
        chk("b_rd_done", 64'(bus_b.ram_wait), 64'd0);
        chk("b_rd_data", 64'(bus_b.ram_dout), 64'hDE2233EF);
        $display("txn B RD addr=3 dout=%0h", bus_b.ram_dout);

        // Drain the scoreboard
        n = 0;
        while (sbq.size() != 0 && n < 200) begin
            @(posedge clk);
            n++;
        end
        #2;
        chk("sb_drain", 64'(sbq.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
